// File: rtl/multi_bank_fifo_arb.sv
// Dual-master banked FIFO: BANK_NUM independent FIFOs, any master may push/pop any bank
// each cycle; same-bank collisions are settled by per-bank round-robin (push and pop separately).
module multi_bank_fifo_arb #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned BANK_NUM   = 4,
  localparam int unsigned BANK_W    = $clog2(BANK_NUM),
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_m0,
  input  logic [BANK_W-1:0]         wr_id_m0,
  input  logic [DATA_WIDTH-1:0]     data_in_m0,
  input  logic                      rd_en_m0,
  input  logic [BANK_W-1:0]         rd_id_m0,
  input  logic                      wr_en_m1,
  input  logic [BANK_W-1:0]         wr_id_m1,
  input  logic [DATA_WIDTH-1:0]     data_in_m1,
  input  logic                      rd_en_m1,
  input  logic [BANK_W-1:0]         rd_id_m1,
  output logic                      wr_ack_m0,
  output logic                      wr_ack_m1,
  output logic                      valid_m0,
  output logic [DATA_WIDTH-1:0]     data_out_m0,
  output logic                      valid_m1,
  output logic [DATA_WIDTH-1:0]     data_out_m1,
  output logic [BANK_NUM-1:0]       bank_full,
  output logic [BANK_NUM-1:0]       bank_empty,
  output logic [BANK_NUM*CNT_W-1:0] bank_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0]      count  [BANK_NUM];
  logic [PTR_W-1:0]      wr_ptr [BANK_NUM];
  logic [PTR_W-1:0]      rd_ptr [BANK_NUM];
  logic [DATA_WIDTH-1:0] mem    [BANK_NUM][DEPTH];
  logic [BANK_NUM-1:0]   wr_prio;  // 0: M0 wins next push conflict, 1: M1
  logic [BANK_NUM-1:0]   rd_prio;  // 0: M0 wins next pop conflict, 1: M1

  logic                  w_elig0, w_elig1, w_conf;
  logic                  r_elig0, r_elig1, r_conf;
  logic                  rd_gnt0, rd_gnt1;
  logic [BANK_NUM-1:0]   push_hit, pop_hit;

  // Status taken from the registered counts, i.e. the pre-edge state.
  always_comb begin
    bank_full  = '0;
    bank_empty = '0;
    bank_count = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      bank_full[b]                   = (count[b] == CNT_W'(DEPTH));
      bank_empty[b]                  = (count[b] == '0);
      bank_count[b*CNT_W +: CNT_W]   = count[b];
    end
  end

  // Eligibility, conflict resolution and per-bank push/pop strobes.
  always_comb begin
    w_elig0   = wr_en_m0 && !bank_full[wr_id_m0];
    w_elig1   = wr_en_m1 && !bank_full[wr_id_m1];
    w_conf    = w_elig0 && w_elig1 && (wr_id_m0 == wr_id_m1);
    wr_ack_m0 = w_elig0 && !(w_conf && wr_prio[wr_id_m0]);
    wr_ack_m1 = w_elig1 && !(w_conf && !wr_prio[wr_id_m1]);

    r_elig0   = rd_en_m0 && !bank_empty[rd_id_m0];
    r_elig1   = rd_en_m1 && !bank_empty[rd_id_m1];
    r_conf    = r_elig0 && r_elig1 && (rd_id_m0 == rd_id_m1);
    rd_gnt0   = r_elig0 && !(r_conf && rd_prio[rd_id_m0]);
    rd_gnt1   = r_elig1 && !(r_conf && !rd_prio[rd_id_m1]);

    push_hit  = '0;
    pop_hit   = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      push_hit[b] = (wr_ack_m0 && (wr_id_m0 == BANK_W'(b))) ||
                    (wr_ack_m1 && (wr_id_m1 == BANK_W'(b)));
      pop_hit[b]  = (rd_gnt0 && (rd_id_m0 == BANK_W'(b))) ||
                    (rd_gnt1 && (rd_id_m1 == BANK_W'(b)));
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ack_m0) mem[wr_id_m0][wr_ptr[wr_id_m0]] <= data_in_m0;
    if (wr_ack_m1) mem[wr_id_m1][wr_ptr[wr_id_m1]] <= data_in_m1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        count[b]  <= '0;
        wr_ptr[b] <= '0;
        rd_ptr[b] <= '0;
      end
      wr_prio     <= '0;
      rd_prio     <= '0;
      valid_m0    <= 1'b0;
      valid_m1    <= 1'b0;
      data_out_m0 <= '0;
      data_out_m1 <= '0;
    end else begin
      for (int b = 0; b < BANK_NUM; b++) begin
        if (push_hit[b]) wr_ptr[b] <= wr_ptr[b] + PTR_W'(1);
        if (pop_hit[b])  rd_ptr[b] <= rd_ptr[b] + PTR_W'(1);
        if (push_hit[b] && !pop_hit[b])      count[b] <= count[b] + CNT_W'(1);
        else if (pop_hit[b] && !push_hit[b]) count[b] <= count[b] - CNT_W'(1);
      end
      // The loser of a conflict gets priority next time on that bank.
      if (w_conf) wr_prio[wr_id_m0] <= !wr_prio[wr_id_m0];
      if (r_conf) rd_prio[rd_id_m0] <= !rd_prio[rd_id_m0];
      valid_m0 <= rd_gnt0;
      valid_m1 <= rd_gnt1;
      if (rd_gnt0) data_out_m0 <= mem[rd_id_m0][rd_ptr[rd_id_m0]];
      if (rd_gnt1) data_out_m1 <= mem[rd_id_m1][rd_ptr[rd_id_m1]];
    end
  end

endmodule

// File: tb/tb_multi_bank_fifo_arb.sv
// Bench for multi_bank_fifo_arb: directed scenarios on the default build plus randomized
// traffic on the default and a 16-bit/4-deep/8-bank build, checked against a queue model.
module tb_multi_bank_fifo_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel;  // 0: default instance driven, 1: wide instance driven
  logic        wen0, wen1, ren0, ren1;
  logic [2:0]  wid0, wid1, rid0, rid1;
  logic [15:0] din0, din1;

  logic        a_ack0, a_ack1, a_v0, a_v1;
  logic [7:0]  a_d0, a_d1;
  logic [3:0]  a_full, a_empty;
  logic [23:0] a_cnt;
  logic        b_ack0, b_ack1, b_v0, b_v1;
  logic [15:0] b_d0, b_d1;
  logic [7:0]  b_full, b_empty;
  logic [23:0] b_cnt;

  int nvec = 0;
  int nerr = 0;

  multi_bank_fifo_arb #(.DATA_WIDTH(8), .DEPTH(32), .BANK_NUM(4)) u_a (
    .clk(clk), .rst(rst),
    .wr_en_m0(wen0 && !sel), .wr_id_m0(wid0[1:0]), .data_in_m0(din0[7:0]),
    .rd_en_m0(ren0 && !sel), .rd_id_m0(rid0[1:0]),
    .wr_en_m1(wen1 && !sel), .wr_id_m1(wid1[1:0]), .data_in_m1(din1[7:0]),
    .rd_en_m1(ren1 && !sel), .rd_id_m1(rid1[1:0]),
    .wr_ack_m0(a_ack0), .wr_ack_m1(a_ack1),
    .valid_m0(a_v0), .data_out_m0(a_d0), .valid_m1(a_v1), .data_out_m1(a_d1),
    .bank_full(a_full), .bank_empty(a_empty), .bank_count(a_cnt)
  );

  multi_bank_fifo_arb #(.DATA_WIDTH(16), .DEPTH(4), .BANK_NUM(8)) u_b (
    .clk(clk), .rst(rst),
    .wr_en_m0(wen0 && sel), .wr_id_m0(wid0), .data_in_m0(din0),
    .rd_en_m0(ren0 && sel), .rd_id_m0(rid0),
    .wr_en_m1(wen1 && sel), .wr_id_m1(wid1), .data_in_m1(din1),
    .rd_en_m1(ren1 && sel), .rd_id_m1(rid1),
    .wr_ack_m0(b_ack0), .wr_ack_m1(b_ack1),
    .valid_m0(b_v0), .data_out_m0(b_d0), .valid_m1(b_v1), .data_out_m1(b_d1),
    .bank_full(b_full), .bank_empty(b_empty), .bank_count(b_cnt)
  );

  // Outputs of whichever instance is selected, zero-extended to the wider shape.
  logic        o_ack0, o_ack1, o_v0, o_v1;
  logic [15:0] o_d0, o_d1;
  logic [7:0]  o_full, o_empty;
  assign o_ack0  = sel ? b_ack0 : a_ack0;
  assign o_ack1  = sel ? b_ack1 : a_ack1;
  assign o_v0    = sel ? b_v0 : a_v0;
  assign o_v1    = sel ? b_v1 : a_v1;
  assign o_d0    = sel ? b_d0 : {8'h00, a_d0};
  assign o_d1    = sel ? b_d1 : {8'h00, a_d1};
  assign o_full  = sel ? b_full : {4'h0, a_full};
  assign o_empty = sel ? b_empty : {4'h0, a_empty};

  function automatic int cnt_of(input logic s, input int b);
    return s ? int'(b_cnt[b*3 +: 3]) : int'(a_cnt[b*6 +: 6]);
  endfunction

  // Reference model: one queue per bank plus the two priority flags per bank.
  logic [15:0] mq [8][$];
  bit          mwp [8];
  bit          mrp [8];
  logic [15:0] ed0, ed1;

  task automatic model_clear();
    for (int b = 0; b < 8; b++) begin
      mq[b].delete();
      mwp[b] = 1'b0;
      mrp[b] = 1'b0;
    end
    ed0 = '0;
    ed1 = '0;
  endtask

  task automatic idle();
    wen0 = 1'b0; wen1 = 1'b0; ren0 = 1'b0; ren1 = 1'b0;
    wid0 = '0; wid1 = '0; rid0 = '0; rid1 = '0;
    din0 = '0; din1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    sel = 1'b0;
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    nvec++; if (a_empty !== 4'hF) begin nerr++; $display("FAIL reset_empty: got %h want f", a_empty); end
    nvec++; if (a_full !== 4'h0) begin nerr++; $display("FAIL reset_full: got %h want 0", a_full); end
    nvec++; if (a_cnt !== 24'h0) begin nerr++; $display("FAIL reset_count: got %h want 0", a_cnt); end
    nvec++; if ({a_v0, a_v1} !== 2'b00) begin nerr++; $display("FAIL reset_valid: got %b want 00", {a_v0, a_v1}); end
    nvec++; if ({a_d0, a_d1} !== 16'h0) begin nerr++; $display("FAIL reset_data: got %h want 0", {a_d0, a_d1}); end
  endtask

  task automatic test_fifo_order();
    do_reset();
    @(negedge clk); wen0 = 1'b1; wid0 = 3'd2; din0 = 16'h11; #1;
    nvec++; if (a_ack0 !== 1'b1) begin nerr++; $display("FAIL order_ack1: got %b want 1", a_ack0); end
    @(negedge clk); din0 = 16'h22; #1;
    nvec++; if (a_ack0 !== 1'b1) begin nerr++; $display("FAIL order_ack2: got %b want 1", a_ack0); end
    @(negedge clk); idle(); ren1 = 1'b1; rid1 = 3'd2;
    @(posedge clk); #1;
    nvec++; if ({a_v1, a_d1} !== {1'b1, 8'h11}) begin nerr++; $display("FAIL order_pop1: got %b/%h want 1/11", a_v1, a_d1); end
    @(posedge clk); #1;
    nvec++; if ({a_v1, a_d1} !== {1'b1, 8'h22}) begin nerr++; $display("FAIL order_pop2: got %b/%h want 1/22", a_v1, a_d1); end
    @(negedge clk); idle();
    @(posedge clk); #1;
    nvec++; if ({a_v1, a_d1} !== {1'b0, 8'h22}) begin nerr++; $display("FAIL order_hold: got %b/%h want 0/22", a_v1, a_d1); end
    nvec++; if (a_empty[2] !== 1'b1) begin nerr++; $display("FAIL order_empty: got %b want 1", a_empty[2]); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); wen0 = 1'b1; wid0 = 3'd0; din0 = 16'(8'h40 + i); #1;
      nvec++; if (a_ack0 !== 1'b1) begin nerr++; $display("FAIL full_fill_ack%0d: got %b want 1", i, a_ack0); end
    end
    @(negedge clk); din0 = 16'hEE; #1;
    nvec++; if (a_full[0] !== 1'b1) begin nerr++; $display("FAIL full_flag: got %b want 1", a_full[0]); end
    nvec++; if (a_ack0 !== 1'b0) begin nerr++; $display("FAIL full_33rd_ack: got %b want 0", a_ack0); end
    @(posedge clk); #1;
    nvec++; if (a_cnt[5:0] !== 6'd32) begin nerr++; $display("FAIL full_count: got %0d want 32", a_cnt[5:0]); end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); idle(); ren0 = 1'b1; rid0 = 3'd0;
      @(posedge clk); #1;
      nvec++;
      if ({a_v0, a_d0} !== {1'b1, 8'(8'h40 + i)}) begin
        nerr++; $display("FAIL full_drain%0d: got %b/%h want 1/%h", i, a_v0, a_d0, 8'(8'h40 + i));
      end
    end
    @(negedge clk); idle(); #1;
    nvec++; if ({a_empty[0], a_cnt[5:0]} !== {1'b1, 6'd0}) begin nerr++; $display("FAIL full_drained: got %b/%0d want 1/0", a_empty[0], a_cnt[5:0]); end
  endtask

  task automatic test_arbitration();
    logic [7:0] exp_pop [3];
    exp_pop[0] = 8'hA0; exp_pop[1] = 8'hB1; exp_pop[2] = 8'hA2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wen0 = 1'b1; wen1 = 1'b1; wid0 = 3'd1; wid1 = 3'd1;
      din0 = 16'(8'hA0 + i); din1 = 16'(8'hB0 + i); #1;
      nvec++;
      if ({a_ack0, a_ack1} !== {(i % 2) == 0, (i % 2) == 1}) begin
        nerr++; $display("FAIL arb_wr%0d: got %b%b want %b%b", i, a_ack0, a_ack1, (i % 2) == 0, (i % 2) == 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); ren0 = 1'b1; ren1 = 1'b1; rid0 = 3'd1; rid1 = 3'd1;
      @(posedge clk); #1;
      nvec++;
      if ({a_v0, a_v1} !== {(i % 2) == 0, (i % 2) == 1}) begin
        nerr++; $display("FAIL arb_rd_valid%0d: got %b%b want %b%b", i, a_v0, a_v1, (i % 2) == 0, (i % 2) == 1);
      end
      nvec++;
      if (((i % 2) == 0 ? a_d0 : a_d1) !== exp_pop[i]) begin
        nerr++; $display("FAIL arb_rd_data%0d: got %h want %h", i, ((i % 2) == 0 ? a_d0 : a_d1), exp_pop[i]);
      end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_edge();
    do_reset();
    @(negedge clk); ren0 = 1'b1; rid0 = 3'd3;
    @(posedge clk); #1;
    nvec++; if ({a_v0, a_cnt[23:18]} !== {1'b0, 6'd0}) begin nerr++; $display("FAIL edge_pop_empty: got %b/%0d want 0/0", a_v0, a_cnt[23:18]); end
    @(negedge clk); idle(); wen1 = 1'b1; wid1 = 3'd3; din1 = 16'h55; ren0 = 1'b1; rid0 = 3'd3; #1;
    nvec++; if (a_ack1 !== 1'b1) begin nerr++; $display("FAIL edge_push_ack: got %b want 1", a_ack1); end
    @(posedge clk); #1;
    nvec++; if ({a_v0, a_cnt[23:18]} !== {1'b0, 6'd1}) begin nerr++; $display("FAIL edge_pop_refused: got %b/%0d want 0/1", a_v0, a_cnt[23:18]); end
    @(negedge clk); idle(); wen0 = 1'b1; wid0 = 3'd3; din0 = 16'h66; ren1 = 1'b1; rid1 = 3'd3; #1;
    nvec++; if (a_ack0 !== 1'b1) begin nerr++; $display("FAIL edge_pushpop_ack: got %b want 1", a_ack0); end
    @(posedge clk); #1;
    nvec++; if ({a_v1, a_d1, a_cnt[23:18]} !== {1'b1, 8'h55, 6'd1}) begin nerr++; $display("FAIL edge_pushpop: got %b/%h/%0d want 1/55/1", a_v1, a_d1, a_cnt[23:18]); end
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); wen0 = 1'b1; wid0 = 3'd0; din0 = 16'h7A; wen1 = 1'b1; wid1 = 3'd2; din1 = 16'h7B;
    @(negedge clk); idle(); ren0 = 1'b1; rid0 = 3'd0; ren1 = 1'b1; rid1 = 3'd2;
    @(posedge clk); #1;
    nvec++; if ({a_v0, a_v1} !== 2'b11) begin nerr++; $display("FAIL midrst_pre: got %b want 11", {a_v0, a_v1}); end
    @(negedge clk); wen0 = 1'b1; wid0 = 3'd1; ren0 = 1'b0; ren1 = 1'b0;
    @(posedge clk); #2; idle(); ren0 = 1'b1; rid0 = 3'd1;
    #1; rst = 1'b1; #1;
    nvec++; if ({a_v0, a_v1, a_empty, a_cnt} !== {2'b00, 4'hF, 24'h0}) begin nerr++; $display("FAIL midrst_state: got %b%b/%h/%h want 00/f/0", a_v0, a_v1, a_empty, a_cnt); end
    @(negedge clk); rst = 1'b0; idle();
    @(posedge clk); #1;
    nvec++; if ({a_v0, a_empty} !== {1'b0, 4'hF}) begin nerr++; $display("FAIL midrst_after: got %b/%h want 0/f", a_v0, a_empty); end
  endtask

  task automatic test_random(input logic inst, input int ncyc, input int depth, input int nb, input logic [15:0] dmask);
    bit e0, e1, p0, p1;
    int wp;
    sel = inst;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      wp = ((c % 400) < 200) ? 75 : 30;
      @(negedge clk);
      wen0 = int'($urandom_range(0, 99)) < wp;
      wen1 = int'($urandom_range(0, 99)) < wp;
      ren0 = int'($urandom_range(0, 99)) < (105 - wp);
      ren1 = int'($urandom_range(0, 99)) < (105 - wp);
      wid0 = 3'($urandom_range(0, nb - 1));
      wid1 = 3'($urandom_range(0, nb - 1));
      rid0 = 3'($urandom_range(0, nb - 1));
      rid1 = 3'($urandom_range(0, nb - 1));
      din0 = 16'($urandom) & dmask;
      din1 = 16'($urandom) & dmask;
      #1;
      e0 = wen0 && (mq[wid0].size() < depth);
      e1 = wen1 && (mq[wid1].size() < depth);
      if (e0 && e1 && wid0 == wid1) begin
        if (mwp[wid0]) e0 = 1'b0; else e1 = 1'b0;
        mwp[wid0] = !mwp[wid0];
      end
      p0 = ren0 && (mq[rid0].size() > 0);
      p1 = ren1 && (mq[rid1].size() > 0);
      if (p0 && p1 && rid0 == rid1) begin
        if (mrp[rid0]) p0 = 1'b0; else p1 = 1'b0;
        mrp[rid0] = !mrp[rid0];
      end
      nvec++; if ({o_ack0, o_ack1} !== {e0, e1}) begin nerr++; $display("FAIL rnd%0d_ack c%0d: got %b%b want %b%b", inst, c, o_ack0, o_ack1, e0, e1); end
      if (p0) ed0 = mq[rid0].pop_front();
      if (p1) ed1 = mq[rid1].pop_front();
      if (e0) mq[wid0].push_back(din0);
      if (e1) mq[wid1].push_back(din1);
      @(posedge clk); #1;
      nvec++;
      if ({o_v0, o_d0, o_v1, o_d1} !== {p0, ed0, p1, ed1}) begin
        nerr++; $display("FAIL rnd%0d_pop c%0d: got %b/%h %b/%h want %b/%h %b/%h", inst, c, o_v0, o_d0, o_v1, o_d1, p0, ed0, p1, ed1);
      end
      for (int b = 0; b < nb; b++) begin
        nvec++;
        if (cnt_of(sel, b) != mq[b].size() || o_full[b] !== (mq[b].size() == depth) || o_empty[b] !== (mq[b].size() == 0)) begin
          nerr++; $display("FAIL rnd%0d_bank%0d c%0d: got cnt %0d f%b e%b want cnt %0d", inst, b, c, cnt_of(sel, b), o_full[b], o_empty[b], mq[b].size());
        end
      end
    end
    // Reset in the middle of live traffic.
    @(negedge clk);
    wen0 = 1'b1; ren0 = 1'b1; wen1 = 1'b1; ren1 = 1'b1;
    #1; rst = 1'b1; #1;
    model_clear();
    for (int b = 0; b < nb; b++) begin
      nvec++;
      if (cnt_of(sel, b) != 0 || o_empty[b] !== 1'b1 || o_full[b] !== 1'b0) begin
        nerr++; $display("FAIL rnd%0d_rst_bank%0d: got cnt %0d f%b e%b want 0/0/1", inst, b, cnt_of(sel, b), o_full[b], o_empty[b]);
      end
    end
    nvec++; if ({o_v0, o_v1} !== 2'b00) begin nerr++; $display("FAIL rnd%0d_rst_valid: got %b%b want 00", inst, o_v0, o_v1); end
    @(negedge clk); rst = 1'b0; idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sel = 1'b0;
    idle();
    model_clear();
    test_reset();
    test_fifo_order();
    test_full();
    test_arbitration();
    test_edge();
    test_reset_mid();
    test_random(1'b0, 5000, 32, 4, 16'h00FF);
    test_random(1'b1, 5000, 4, 8, 16'hFFFF);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
